// File: rtl/comb_calc_pkg.sv
// Shared opcodes and seven-segment patterns for the 4-bit signed calculator.
// Segments are active-low with bit0=a through bit6=g.
package comb_calc_pkg;

  localparam int W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ABS = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b011;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Magnitudes above 8 cannot come from a 4-bit signed value.
  function automatic logic [6:0] seg_digit(
    input logic [W-1:0] mag
  );
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (mag)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/signed_hex_display.sv
// Sign and magnitude digit pair for one 4-bit two's complement value.
// -8 negates to 4'b1000, read unsigned as 8.
module signed_hex_display
  import comb_calc_pkg::*;
(
  input  logic [W-1:0] value,
  output logic [6:0]   sign_seg,
  output logic [6:0]   mag_seg
);

  logic [W-1:0] mag;

  always_comb begin
    mag      = value[W-1] ? (~value + 4'd1) : value;
    sign_seg = value[W-1] ? SEG_MINUS : SEG_BLANK;
    mag_seg  = seg_digit(mag);
  end

endmodule

// File: rtl/comb_calc.sv
// Registered-input 4-bit signed ALU with seven-segment readout.
// Result, overflow and displays are combinational from the input registers.
module comb_calc
  import comb_calc_pkg::*;
(
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic [2:0]   KEY,
  input  logic [7:0]   SW,
  output logic [6:0]   HEX7,
  output logic [6:0]   HEX6,
  output logic [6:0]   HEX5,
  output logic [6:0]   HEX4,
  output logic [6:0]   HEX3,
  output logic [6:0]   HEX2,
  output logic [6:0]   HEX0,
  output logic [W-1:0] R,
  output logic         ovf
);

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [2:0]   op_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD;
    end else begin
      a_q  <= SW[7:4];
      b_q  <= SW[3:0];
      op_q <= KEY;
    end
  end

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic [W-1:0] neg_a;
  logic         a_min;

  assign sum   = a_q + b_q;
  assign diff  = a_q - b_q;
  assign neg_a = ~a_q + 4'd1;
  assign a_min = (a_q == 4'b1000);

  always_comb begin
    R   = '0;
    ovf = 1'b0;
    unique case (1'b1)
      (op_q == OP_ADD): begin
        R   = sum;
        ovf = (a_q[3] == b_q[3]) && (sum[3] != a_q[3]);
      end
      (op_q == OP_SUB): begin
        R   = diff;
        ovf = (a_q[3] != b_q[3]) && (diff[3] != a_q[3]);
      end
      (op_q == OP_ABS): begin
        R   = a_q[3] ? neg_a : a_q;
        ovf = a_min;
      end
      (op_q == OP_NEG): begin
        R   = neg_a;
        ovf = a_min;
      end
      op_q[2]: begin
        R   = '0;
        ovf = 1'b0;
      end
      default: begin
        R   = '0;
        ovf = 1'b0;
      end
    endcase
  end

  assign HEX0 = ovf ? SEG_E : SEG_BLANK;

  signed_hex_display u_disp_a (
    .value    (a_q),
    .sign_seg (HEX7),
    .mag_seg  (HEX6)
  );

  signed_hex_display u_disp_b (
    .value    (b_q),
    .sign_seg (HEX5),
    .mag_seg  (HEX4)
  );

  signed_hex_display u_disp_r (
    .value    (R),
    .sign_seg (HEX3),
    .mag_seg  (HEX2)
  );

endmodule

// File: tb/tb_comb_calc.sv
// Scoreboard bench for comb_calc: integer reference model, random and
// directed stimulus, monitor checking one cycle after each capture.
module tb_comb_calc;

  logic       clk;
  logic       reset;
  logic [2:0] KEY;
  logic [7:0] SW;
  logic [6:0] HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX0;
  logic [3:0] R;
  logic       ovf;

  comb_calc dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .KEY      (KEY),
    .SW       (SW),
    .HEX7     (HEX7),
    .HEX6     (HEX6),
    .HEX5     (HEX5),
    .HEX4     (HEX4),
    .HEX3     (HEX3),
    .HEX2     (HEX2),
    .HEX0     (HEX0),
    .R        (R),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r;
    logic       ovf;
    logic [6:0] h7, h6, h5, h4, h3, h2, h0;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [6:0] digit(input int m);
    logic [6:0] tbl [9];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100,
            7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1111000, 7'b0000000};
    return tbl[m];
  endfunction

  function automatic logic [6:0] sgn(input int v);
    return (v < 0) ? 7'b0111111 : 7'b1111111;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Exact integer result, then wrapped to 4 bits; overflow means out of range.
  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    int   x;
    int   rs;
    case (op)
      0:       x = a + b;
      1:       x = a - b;
      2:       x = absi(a);
      3:       x = -a;
      default: x = 0;
    endcase
    e.r   = 4'(x & 15);
    e.ovf = (x > 7) || (x < -8);
    rs    = (int'(e.r) >= 8) ? int'(e.r) - 16 : int'(e.r);
    e.h7  = sgn(a);
    e.h6  = digit(absi(a));
    e.h5  = sgn(b);
    e.h4  = digit(absi(b));
    e.h3  = sgn(rs);
    e.h2  = digit(absi(rs));
    e.h0  = e.ovf ? 7'b0000110 : 7'b1111111;
    return e;
  endfunction

  function automatic int s4(input logic [3:0] v);
    return (int'(v) >= 8) ? int'(v) - 16 : int'(v);
  endfunction

  task automatic drive(input logic rst, input logic [2:0] k,
                       input logic [7:0] s);
    @(negedge clk);
    reset = rst;
    KEY   = k;
    SW    = s;
    if (rst) exp_q.push_back(model(0, 0, 0));
    else exp_q.push_back(model(s4(s[7:4]), s4(s[3:0]), int'(k)));
  endtask

  task automatic chk(input string name, input logic [6:0] act,
                     input logic [6:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("R",    {3'b0, R},   {3'b0, e.r});
        chk("ovf",  {6'b0, ovf}, {6'b0, e.ovf});
        chk("HEX7", HEX7, e.h7);
        chk("HEX6", HEX6, e.h6);
        chk("HEX5", HEX5, e.h5);
        chk("HEX4", HEX4, e.h4);
        chk("HEX3", HEX3, e.h3);
        chk("HEX2", HEX2, e.h2);
        chk("HEX0", HEX0, e.h0);
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1;
    KEY   = '0;
    SW    = '0;
    drive(1'b1, 3'b101, 8'hA7);
    drive(1'b1, 3'b011, 8'h80);
    drive(1'b0, 3'b000, 8'h01);
    drive(1'b0, 3'b000, 8'h71);
    drive(1'b0, 3'b000, 8'hEF);
    drive(1'b0, 3'b000, 8'h8F);
    drive(1'b0, 3'b001, 8'h3B);
    drive(1'b0, 3'b001, 8'hD2);
    drive(1'b0, 3'b010, 8'h50);
    drive(1'b0, 3'b010, 8'hA0);
    drive(1'b0, 3'b010, 8'h80);
    drive(1'b0, 3'b011, 8'h80);
    drive(1'b0, 3'b011, 8'h70);
    drive(1'b0, 3'b111, 8'h88);
    drive(1'b0, 3'b100, 8'h7F);
    drive(1'b1, 3'b001, 8'h3B);
    drive(1'b0, 3'b001, 8'h88);
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 31) == 0), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)));
    end
    for (int a = 0; a < 16; a++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b0, 3'(k), {4'(a), 4'(15 - a)});
      end
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comb_calc.md
COMB_CALC -- requirements
Module: comb_calc

Interface
REQ-001 Parameter: none; data width fixed at 4 bits, two's complement.
REQ-002 CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 KEY  input  3  operation select (opcode).
REQ-005 SW  input  8  SW[7:4] = operand A, SW[3:0] = operand B, both signed.
REQ-006 HEX7, HEX6  output  7 each  A display: HEX7 sign, HEX6 magnitude.
REQ-007 HEX5, HEX4  output  7 each  B display: HEX5 sign, HEX4 magnitude.
REQ-008 HEX3, HEX2  output  7 each  R display: HEX3 sign, HEX2 magnitude.
REQ-009 HEX0  output  7  overflow indicator.
REQ-010 R  output  4  signed result.
REQ-011 ovf  output  1  signed overflow flag.

Function
REQ-012 Each rising edge SHALL capture SW and KEY into input registers; R, ovf and all HEX outputs SHALL be combinational from those registers (latency 1 cycle).
REQ-013 Opcodes: 000 ADD R=A+B; 001 SUB R=A-B; 010 ABS R=|A|; 011 NEG R=-A; 100-111 R=0, ovf=0.
REQ-014 R SHALL be the low 4 bits of the exact result (wrap-around).
REQ-015 ADD ovf=1 iff A,B same sign and R sign differs.
REQ-016 SUB ovf=1 iff A,B signs differ and R sign differs from A.
REQ-017 ABS and NEG ovf=1 iff A=-8 (R=-8); otherwise ovf=0.
REQ-018 Segment encoding active-low, bit0=a ... bit6=g.
REQ-019 Sign digit: 0111111 (minus, g only) when value negative, else 1111111 (blank).
REQ-020 Magnitude digit: decimal 0-8 of |value|; -8 shows minus and 8.
REQ-021 Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000.
REQ-022 HEX0 SHALL show E (0000110) when ovf=1, else blank (1111111).
REQ-023 R display SHALL show wrapped R even when ovf=1.

Reset
REQ-024 reset=1 at a rising edge SHALL clear A, B and opcode registers to 0, so R=0, ovf=0, HEX7/5/3 blank, HEX6/4/2 show 0, HEX0 blank, from the next cycle.
REQ-025 reset SHALL take priority over input capture; the first capture after deassertion occurs at the next edge.

Structure
REQ-026 Shared package comb_calc_pkg SHALL hold opcode constants and segment patterns (digits, minus, blank, E).
REQ-027 One sub-module signed_hex_display (4-bit signed in, sign and magnitude segments out) SHALL be instantiated three times, for A, B and R.
REQ-028 ALU logic and input registers SHALL reside in comb_calc.

Verification
REQ-029 Reset asserted, then released -> R=0, ovf=0, HEX6/4/2=1000000, HEX0=1111111.
REQ-030 KEY=000, SW=0000_0001 -> one cycle later R=1, ovf=0, HEX2=1111001.
REQ-031 KEY=000, A=0111, B=0001 (7+1) -> R=-8 (1000), ovf=1, HEX3=0111111, HEX2=0000000, HEX0=0000110.
REQ-032 KEY=000, A=1110, B=1111 (-2+-1) -> R=-3, ovf=0; A=1000, B=1111 (-8+-1) -> R=7, ovf=1.
REQ-033 KEY=001, A=0011, B=1011 (3-(-5)) -> R=-8, ovf=1; A=1101, B=0010 (-3-2) -> R=-5, ovf=0.
REQ-034 KEY=010, A=0101 -> R=5, ovf=0; A=1010 -> R=6, ovf=0; A=1000 -> R=-8, ovf=1.
